lfsr_gen: RTL

Pseudo-random bit source for the LFSR statistics path. A WIDTH-bit Fibonacci LFSR with seed load, free-run, burst and single-step control, and a programmable shift-rate divider. Drives the downstream ones/zeros counter with a registered serial bit `i0` qualified by a one-cycle `sh_en` strobe. Also flags completion of a full sequence period.

---
 rtl/lfsr_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR bit source with seed load, free-run, burst and single-step control.
// Emits one registered serial bit per shift, qualified by a one-cycle sh_en strobe.
module lfsr_gen #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1),
    parameter int unsigned      DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic             stop,
    input  logic             burst,
    input  logic [15:0]      burst_len,
    input  logic             step,
    output logic             sh_en,
    output logic             i0,
    output logic [WIDTH-1:0] state,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam int unsigned CNT_W    = 16;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } fsm_e;

    fsm_e             r_fsm;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_ref_seed;
    logic [CNT_W-1:0] r_div_cnt;
    logic [15:0]      r_rem;
    logic             r_sh_en;
    logic             r_i0;
    logic             r_busy;
    logic             r_done;
    logic             r_wrap;

    logic [WIDTH-1:0] w_seed_eff;
    logic             w_fb;
    logic [WIDTH-1:0] w_shifted;
    logic             w_tick;

    // An all-zero seed would lock the LFSR, so it is replaced by SEED.
    assign w_seed_eff = (seed == '0) ? SEED : seed;
    assign w_fb       = ^(r_state & TAPS);
    assign w_shifted  = {r_state[WIDTH-2:0], w_fb};
    assign w_tick     = (r_div_cnt == DIV_LAST);

    // Control FSM, divider, burst counter and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm      <= ST_IDLE;
            r_state    <= SEED;
            r_ref_seed <= SEED;
            r_div_cnt  <= '0;
            r_rem      <= '0;
            r_sh_en    <= 1'b0;
            r_i0       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_sh_en <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            if (load) begin
                r_state    <= w_seed_eff;
                r_ref_seed <= w_seed_eff;
                r_fsm      <= ST_IDLE;
                r_busy     <= 1'b0;
                r_rem      <= '0;
                r_div_cnt  <= '0;
            end else if (stop) begin
                r_fsm     <= ST_IDLE;
                r_busy    <= 1'b0;
                r_rem     <= '0;
                r_div_cnt <= '0;
            end else begin
                case (r_fsm)
                    ST_IDLE: begin
                        r_div_cnt <= '0;
                        if (start) begin
                            r_fsm  <= ST_RUN;
                            r_busy <= 1'b1;
                        end else if (burst) begin
                            // A zero-length burst still wins priority over step.
                            if (burst_len != 16'd0) begin
                                r_fsm  <= ST_BURST;
                                r_busy <= 1'b1;
                                r_rem  <= burst_len;
                            end
                        end else if (step) begin
                            r_fsm  <= ST_BURST;
                            r_busy <= 1'b1;
                            r_rem  <= 16'd1;
                        end
                    end
                    ST_RUN, ST_BURST: begin
                        if (w_tick) begin
                            r_div_cnt <= '0;
                            r_state   <= w_shifted;
                            r_i0      <= r_state[WIDTH-1];
                            r_sh_en   <= 1'b1;
                            r_wrap    <= (w_shifted == r_ref_seed);
                            if (r_fsm == ST_BURST) begin
                                r_rem <= r_rem - 16'd1;
                                if (r_rem == 16'd1) begin
                                    r_done <= 1'b1;
                                    r_fsm  <= ST_IDLE;
                                    r_busy <= 1'b0;
                                end
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_fsm  <= ST_IDLE;
                        r_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sh_en = r_sh_en;
    assign i0    = r_i0;
    assign state = r_state;
    assign busy  = r_busy;
    assign done  = r_done;
    assign wrap  = r_wrap;

endmodule
